// File: rtl/exe_stage_if.sv
// ID/EXE operand and control bundle into the execute stage, plus its EXE/MEM and branch results.
// Latency: none (signal bundle only).
// Backpressure: none; stalls are carried by the separate freeze input of the stage.
interface exe_stage_if;
    // ID/EXE register outputs consumed by the execute stage
    logic        Wb_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        B;
    logic        S;
    logic [3:0]  EXE_CMD;
    logic [31:0] PC;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest;
    logic        C_in;

    // Branch resolution, status flags and EXE/MEM register outputs
    logic        Br_taken;
    logic [31:0] Br_Addr;
    logic [3:0]  Status;
    logic        Wb_EN_out;
    logic        MEM_R_EN_out;
    logic        MEM_W_EN_out;
    logic [31:0] ALU_Res_out;
    logic [31:0] Val_Rm_out;
    logic [3:0]  Dest_out;

    // Execute stage side
    modport slave (
        input  Wb_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, Val_Rn, Val_Rm,
               imm, Shift_operand, Signed_imm_24, Dest, C_in,
        output Br_taken, Br_Addr, Status, Wb_EN_out, MEM_R_EN_out, MEM_W_EN_out,
               ALU_Res_out, Val_Rm_out, Dest_out
    );

    // Pipeline side driving the stage and observing its results
    modport master (
        output Wb_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, Val_Rn, Val_Rm,
               imm, Shift_operand, Signed_imm_24, Dest, C_in,
        input  Br_taken, Br_Addr, Status, Wb_EN_out, MEM_R_EN_out, MEM_W_EN_out,
               ALU_Res_out, Val_Rm_out, Dest_out
    );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: operand-2 shifter, ALU, NZCV status register, branch target, EXE/MEM register.
// Latency: 1 cycle to EXE/MEM outputs and Status; Br_taken/Br_Addr are combinational.
// Backpressure: freeze=1 holds the EXE/MEM register and Status; branch outputs are never held.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         freeze,
    exe_stage_if.slave   bus
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [31:0] val2;
    logic [31:0] alu_res;
    logic [3:0]  alu_flags;
    logic [3:0]  status_q;

    // Second operand: rotated immediate, then memory offset, then shifted register
    always_comb begin
        logic [63:0] dbl;
        logic [4:0]  amt;
        val2 = bus.Val_Rm;
        dbl  = 64'd0;
        amt  = 5'd0;
        if (bus.imm) begin
            // Rotate by doubling the word and shifting; the rotate amount is always even
            amt  = {bus.Shift_operand[11:8], 1'b0};
            dbl  = {24'd0, bus.Shift_operand[7:0], 24'd0, bus.Shift_operand[7:0]} >> amt;
            val2 = dbl[31:0];
        end else if (bus.MEM_R_EN || bus.MEM_W_EN) begin
            val2 = {20'd0, bus.Shift_operand};
        end else begin
            amt = bus.Shift_operand[11:7];
            case (bus.Shift_operand[6:5])
                2'b00: val2 = bus.Val_Rm << amt;
                2'b01: val2 = bus.Val_Rm >> amt;
                2'b10: val2 = $signed(bus.Val_Rm) >>> amt;
                default: begin
                    dbl  = {bus.Val_Rm, bus.Val_Rm} >> amt;
                    val2 = dbl[31:0];
                end
            endcase
        end
    end

    // ALU with 33-bit adder; logic ops keep the current C and V
    always_comb begin
        logic [32:0] sum;
        logic [31:0] opb;
        logic        arith;
        logic        c_flag;
        logic        v_flag;
        sum     = 33'd0;
        opb     = val2;
        arith   = 1'b0;
        alu_res = 32'd0;
        case (bus.EXE_CMD)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD: begin
                arith = 1'b1;
                sum   = {1'b0, bus.Val_Rn} + {1'b0, val2};
            end
            CMD_ADC: begin
                arith = 1'b1;
                sum   = {1'b0, bus.Val_Rn} + {1'b0, val2} + {32'd0, bus.C_in};
            end
            CMD_SUB: begin
                arith = 1'b1;
                opb   = ~val2;
                sum   = {1'b0, bus.Val_Rn} + {1'b0, ~val2} + 33'd1;
            end
            CMD_SBC: begin
                arith = 1'b1;
                opb   = ~val2;
                sum   = {1'b0, bus.Val_Rn} + {1'b0, ~val2} + {32'd0, bus.C_in};
            end
            CMD_AND: alu_res = bus.Val_Rn & val2;
            CMD_ORR: alu_res = bus.Val_Rn | val2;
            CMD_EOR: alu_res = bus.Val_Rn ^ val2;
            default: alu_res = 32'd0;
        endcase
        if (arith) begin
            alu_res = sum[31:0];
        end
        c_flag = arith ? sum[32] : status_q[1];
        // Signed overflow: adder inputs agree in sign but the result does not
        v_flag = arith ? ((bus.Val_Rn[31] == opb[31]) && (alu_res[31] != bus.Val_Rn[31]))
                       : status_q[0];
        alu_flags = {alu_res[31], (alu_res == 32'd0), c_flag, v_flag};
    end

    // Branch target: word offset sign-extended and scaled, wraps modulo 2^32
    always_comb begin
        bus.Br_taken = bus.B;
        bus.Br_Addr  = bus.PC + {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};
    end

    // Status register loads on flag-setting instructions unless frozen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q <= 4'b0000;
        end else if (bus.S && !freeze) begin
            status_q <= alu_flags;
        end
    end

    // EXE/MEM pipeline register; store data is the raw Rm, not the shifted operand
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.Wb_EN_out    <= 1'b0;
            bus.MEM_R_EN_out <= 1'b0;
            bus.MEM_W_EN_out <= 1'b0;
            bus.ALU_Res_out  <= 32'd0;
            bus.Val_Rm_out   <= 32'd0;
            bus.Dest_out     <= 4'd0;
        end else if (!freeze) begin
            bus.Wb_EN_out    <= bus.Wb_EN;
            bus.MEM_R_EN_out <= bus.MEM_R_EN;
            bus.MEM_W_EN_out <= bus.MEM_W_EN;
            bus.ALU_Res_out  <= alu_res;
            bus.Val_Rm_out   <= bus.Val_Rm;
            bus.Dest_out     <= bus.Dest;
        end
    end

    assign bus.Status = status_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, shifter modes, flags, branch target, freeze and async reset.
// Latency: checks registered outputs 1 ns after the capturing edge, branch outputs right after driving.
// Backpressure: exercises freeze holding both the EXE/MEM register and Status.
module tb_exe_stage;

    logic clk;
    logic reset;
    logic freeze;
    int   n_checks;
    int   n_errors;

    exe_stage_if bus ();

    exe_stage dut (
        .clk    (clk),
        .reset  (reset),
        .freeze (freeze),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Wb_EN         = 1'b0;
        bus.MEM_R_EN      = 1'b0;
        bus.MEM_W_EN      = 1'b0;
        bus.B             = 1'b0;
        bus.S             = 1'b0;
        bus.EXE_CMD       = 4'd0;
        bus.PC            = 32'd0;
        bus.Val_Rn        = 32'd0;
        bus.Val_Rm        = 32'd0;
        bus.imm           = 1'b0;
        bus.Shift_operand = 12'd0;
        bus.Signed_imm_24 = 24'd0;
        bus.Dest          = 4'd0;
        bus.C_in          = 1'b0;
    endtask

    // Drive one data-processing instruction with writeback enabled
    task automatic alu_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic im, input logic [11:0] so, input logic s, input logic cin);
        clear_inputs();
        bus.Wb_EN         = 1'b1;
        bus.EXE_CMD       = cmd;
        bus.Val_Rn        = rn;
        bus.Val_Rm        = rm;
        bus.imm           = im;
        bus.Shift_operand = so;
        bus.S             = s;
        bus.C_in          = cin;
        bus.Dest          = 4'd5;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        freeze   = 1'b0;
        reset    = 1'b0;
        clear_inputs();

        // Reset state
        #12;
        check("rst_status", {28'd0, bus.Status}, 32'h0);
        check("rst_alu", bus.ALU_Res_out, 32'h0);
        check("rst_rm", bus.Val_Rm_out, 32'h0);
        check("rst_ctl", {29'd0, bus.Wb_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out}, 32'h0);
        check("rst_dest", {28'd0, bus.Dest_out}, 32'h0);
        reset = 1'b1;

        // ADD overflow into sign bit
        alu_op(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0);
        check("add_br_taken", {31'd0, bus.Br_taken}, 32'h0);
        tick();
        check("add_res", bus.ALU_Res_out, 32'h8000_0000);
        check("add_status", {28'd0, bus.Status}, 32'h9);
        check("add_wb", {31'd0, bus.Wb_EN_out}, 32'h1);
        check("add_dest", {28'd0, bus.Dest_out}, 32'h5);

        // MOV of zero with S: N,Z from result, C,V kept from ADD
        alu_op(4'b0001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1, 1'b0);
        tick();
        check("mov0_status", {28'd0, bus.Status}, 32'h5);

        // CMP 5,5
        alu_op(4'b0100, 32'd5, 32'h0, 1'b1, 12'h005, 1'b1, 1'b0);
        bus.Wb_EN = 1'b0;
        tick();
        check("cmp_status", {28'd0, bus.Status}, 32'h6);
        check("cmp_wb", {31'd0, bus.Wb_EN_out}, 32'h0);
        check("cmp_res", bus.ALU_Res_out, 32'h0);

        // SBC 5-3 with carry in
        alu_op(4'b0101, 32'd5, 32'h0, 1'b1, 12'h003, 1'b1, 1'b1);
        tick();
        check("sbc_res", bus.ALU_Res_out, 32'd2);
        check("sbc_status", {28'd0, bus.Status}, 32'h2);

        // TST-like AND giving zero keeps C=1, V=0
        alu_op(4'b0110, 32'h0000_00F0, 32'h0, 1'b1, 12'h00F, 1'b1, 1'b0);
        tick();
        check("and_res", bus.ALU_Res_out, 32'h0);
        check("and_status", {28'd0, bus.Status}, 32'h6);

        // Rotated immediate, S=0 leaves Status
        alu_op(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0, 1'b0);
        tick();
        check("mov_rotimm", bus.ALU_Res_out, 32'hFF00_0000);
        check("mov_rotimm_status", {28'd0, bus.Status}, 32'h6);

        // Register shifts: ASR #4, ROR #4, LSL #1, LSR #8
        alu_op(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b0, 1'b0);
        tick();
        check("mov_asr", bus.ALU_Res_out, 32'hF800_0000);
        alu_op(4'b0001, 32'h0, 32'h0000_00F1, 1'b0, 12'h260, 1'b0, 1'b0);
        tick();
        check("mov_ror", bus.ALU_Res_out, 32'h1000_000F);
        alu_op(4'b0001, 32'h0, 32'h8000_0001, 1'b0, 12'h080, 1'b0, 1'b0);
        tick();
        check("mov_lsl", bus.ALU_Res_out, 32'h0000_0002);
        alu_op(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h420, 1'b0, 1'b0);
        tick();
        check("mov_lsr", bus.ALU_Res_out, 32'h0080_0000);

        // ORR, EOR, ADC, unused opcode
        alu_op(4'b0111, 32'hF0F0_0000, 32'h0, 1'b1, 12'h0FF, 1'b0, 1'b0);
        tick();
        check("orr_res", bus.ALU_Res_out, 32'hF0F0_00FF);
        alu_op(4'b1000, 32'h0000_00FF, 32'h0, 1'b1, 12'h00F, 1'b0, 1'b0);
        tick();
        check("eor_res", bus.ALU_Res_out, 32'h0000_00F0);
        alu_op(4'b0011, 32'd1, 32'h0, 1'b1, 12'h001, 1'b0, 1'b1);
        tick();
        check("adc_res", bus.ALU_Res_out, 32'd3);
        alu_op(4'b0000, 32'd5, 32'h1234, 1'b1, 12'h001, 1'b0, 1'b0);
        tick();
        check("nop_res", bus.ALU_Res_out, 32'h0);

        // MVN with S: N=1, C/V kept (C=1, V=0)
        alu_op(4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1, 1'b0);
        tick();
        check("mvn_res", bus.ALU_Res_out, 32'hFFFF_FFFF);
        check("mvn_status", {28'd0, bus.Status}, 32'hA);

        // Branch back 2 words together with a flag-setting 0-1
        alu_op(4'b0100, 32'h0, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0);
        bus.B             = 1'b1;
        bus.PC            = 32'h0000_0100;
        bus.Signed_imm_24 = 24'hFFFFFE;
        #1;
        check("br_taken", {31'd0, bus.Br_taken}, 32'h1);
        check("br_addr_back", bus.Br_Addr, 32'h0000_00F8);
        tick();
        check("br_sub_status", {28'd0, bus.Status}, 32'h8);

        // Branch target wraps
        clear_inputs();
        bus.B             = 1'b1;
        bus.PC            = 32'hFFFF_FFFC;
        bus.Signed_imm_24 = 24'h000001;
        #1;
        check("br_addr_wrap", bus.Br_Addr, 32'h0000_0000);
        tick();

        // LDR: memory offset takes priority over the register shifter
        clear_inputs();
        bus.MEM_R_EN      = 1'b1;
        bus.Wb_EN         = 1'b1;
        bus.EXE_CMD       = 4'b0010;
        bus.Val_Rn        = 32'h0;
        bus.Val_Rm        = 32'h1;
        bus.Shift_operand = 12'hFFF;
        tick();
        check("ldr_addr", bus.ALU_Res_out, 32'h0000_0FFF);
        check("ldr_ren", {31'd0, bus.MEM_R_EN_out}, 32'h1);

        // STR: address Rn+offset, store data is raw Rm
        clear_inputs();
        bus.MEM_W_EN      = 1'b1;
        bus.EXE_CMD       = 4'b0010;
        bus.Val_Rn        = 32'h0000_1000;
        bus.Val_Rm        = 32'h0000_DEAD;
        bus.Shift_operand = 12'h004;
        bus.Dest          = 4'd3;
        tick();
        check("str_addr", bus.ALU_Res_out, 32'h0000_1004);
        check("str_data", bus.Val_Rm_out, 32'h0000_DEAD);
        check("str_ctl", {29'd0, bus.Wb_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out}, 32'h1);

        // Freeze two cycles with a flag-setting ADD pending
        freeze = 1'b1;
        alu_op(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0);
        bus.Dest = 4'd9;
        tick();
        tick();
        check("frz_res", bus.ALU_Res_out, 32'h0000_1004);
        check("frz_status", {28'd0, bus.Status}, 32'h8);
        check("frz_data", bus.Val_Rm_out, 32'h0000_DEAD);
        check("frz_dest", {28'd0, bus.Dest_out}, 32'h3);
        freeze = 1'b0;
        tick();
        check("unfrz_res", bus.ALU_Res_out, 32'h8000_0000);
        check("unfrz_status", {28'd0, bus.Status}, 32'h9);
        check("unfrz_wen", {31'd0, bus.MEM_W_EN_out}, 32'h0);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_res", bus.ALU_Res_out, 32'h0);
        check("arst_status", {28'd0, bus.Status}, 32'h0);
        check("arst_wb", {31'd0, bus.Wb_EN_out}, 32'h0);
        check("arst_dest", {28'd0, bus.Dest_out}, 32'h0);
        #2;
        reset = 1'b1;
        tick();
        check("post_rst_res", bus.ALU_Res_out, 32'h8000_0000);
        check("post_rst_status", {28'd0, bus.Status}, 32'h9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
